// File: rtl/control_output_limit_pkg.sv
// rtl/control_output_limit_pkg.sv - shared float constants, sat encoding, FSM states and ordering helpers
// Purpose: single-precision width/constants, 2-bit saturation code, sequencing states,
//          and the sign-magnitude-to-unsigned ordering key used by the clamp datapath.
package control_output_limit_pkg;

  localparam int SINGLE_W = 32;
  typedef logic [SINGLE_W-1:0] single_t;

  localparam single_t    FP_POS_ZERO = 32'h0000_0000;
  localparam single_t    FP_NEG_ZERO = 32'h8000_0000;
  localparam logic [7:0] FP_EXP_MAX  = 8'hFF;

  typedef enum logic [1:0] {
    SAT_NONE = 2'b00,
    SAT_LOW  = 2'b01,
    SAT_HIGH = 2'b10,
    SAT_NAN  = 2'b11
  } sat_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMP1,
    ST_CMP2,
    ST_UPDATE
  } state_e;

  // Negative values invert fully so larger magnitudes sort lower; positive values
  // get the top bit set so they sort above every negative value.
  function automatic single_t fp_key(input single_t x);
    return x[31] ? ~x : {1'b1, x[30:0]};
  endfunction

  function automatic logic fp_is_nan(input single_t x);
    return (x[30:23] == FP_EXP_MAX) && (x[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/control_output_limit_float_clamp.sv
// rtl/control_output_limit_float_clamp.sv - combinational single-precision clamp with sat code
// Purpose: normalise -0, order by unsigned key, clamp against [i_min, i_max].
// Ports:
//   i_x    value to limit
//   i_max  upper limit (trusted i_min <= i_max)
//   i_min  lower limit
//   o_y    limited value
//   o_sat  saturation status (none / low / high / NaN)
module control_output_limit_float_clamp
  import control_output_limit_pkg::*;
(
  input  single_t i_x,
  input  single_t i_max,
  input  single_t i_min,
  output single_t o_y,
  output sat_e    o_sat
);

  single_t w_x_norm;
  single_t w_key_x;
  single_t w_key_max;
  single_t w_key_min;

  assign w_x_norm  = (i_x == FP_NEG_ZERO) ? FP_POS_ZERO : i_x;
  assign w_key_x   = fp_key(w_x_norm);
  assign w_key_max = fp_key(i_max);
  assign w_key_min = fp_key(i_min);

  always_comb begin
    o_y   = w_x_norm;
    o_sat = SAT_NONE;
    if (fp_is_nan(i_x)) begin
      o_y   = i_min;
      o_sat = SAT_NAN;
    end else if (w_key_x > w_key_max) begin
      o_y   = i_max;
      o_sat = SAT_HIGH;
    end else if (w_key_x < w_key_min) begin
      o_y   = i_min;
      o_sat = SAT_LOW;
    end
  end

endmodule

// File: rtl/control_output_limit.sv
// rtl/control_output_limit.sv - two-channel float output limiter with atomic update
// Purpose: capture two PI outputs on i_sta, clamp each through one shared clamp
//          (channel 1 in CMP1, channel 2 in CMP2), publish both in UPDATE with a done pulse.
// Ports:
//   i_clk, i_rst (async active-low), i_rst_user (sync active-high clear)
//   i_sta, i_input_1, i_input_2     start pulse and the two unlimited values
//   o_output_1, o_output_2          limited values, held between updates
//   o_sat_1, o_sat_2                2-bit saturation status per channel
//   o_done_sig, o_busy, o_overrun   completion pulse, in-flight flag, sticky overrun
module control_output_limit
  import control_output_limit_pkg::*;
#(
  parameter single_t LIM1_MAX = 32'h3F80_0000,
  parameter single_t LIM1_MIN = 32'h0000_0000,
  parameter single_t LIM2_MAX = 32'h3F80_0000,
  parameter single_t LIM2_MIN = 32'h0000_0000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_rst_user,
  input  logic          i_sta,
  input  logic [31:0]   i_input_1,
  input  logic [31:0]   i_input_2,
  output logic [31:0]   o_output_1,
  output logic [31:0]   o_output_2,
  output logic [1:0]    o_sat_1,
  output logic [1:0]    o_sat_2,
  output logic          o_done_sig,
  output logic          o_busy,
  output logic          o_overrun
);

  state_e  r_state;
  single_t r_in_1, r_in_2;
  single_t r_res_1, r_res_2;
  sat_e    r_st_sat_1, r_st_sat_2;
  single_t r_out_1, r_out_2;
  sat_e    r_sat_1, r_sat_2;
  logic    r_done, r_busy, r_overrun;

  single_t w_x, w_max, w_min, w_y;
  sat_e    w_sat;

  // Clamp is time-shared: channel 2 operands only while in CMP2.
  assign w_x   = (r_state == ST_CMP2) ? r_in_2   : r_in_1;
  assign w_max = (r_state == ST_CMP2) ? LIM2_MAX : LIM1_MAX;
  assign w_min = (r_state == ST_CMP2) ? LIM2_MIN : LIM1_MIN;

  control_output_limit_float_clamp u_clamp (
    .i_x   (w_x),
    .i_max (w_max),
    .i_min (w_min),
    .o_y   (w_y),
    .o_sat (w_sat)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= ST_IDLE;
      r_in_1     <= FP_POS_ZERO;
      r_in_2     <= FP_POS_ZERO;
      r_res_1    <= FP_POS_ZERO;
      r_res_2    <= FP_POS_ZERO;
      r_st_sat_1 <= SAT_NONE;
      r_st_sat_2 <= SAT_NONE;
      r_out_1    <= FP_POS_ZERO;
      r_out_2    <= FP_POS_ZERO;
      r_sat_1    <= SAT_NONE;
      r_sat_2    <= SAT_NONE;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (i_rst_user) begin
      // Aborts any conversion; a coincident sta is dropped.
      r_state   <= ST_IDLE;
      r_out_1   <= FP_POS_ZERO;
      r_out_2   <= FP_POS_ZERO;
      r_sat_1   <= SAT_NONE;
      r_sat_2   <= SAT_NONE;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_sta && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_sta) begin
            r_in_1  <= i_input_1;
            r_in_2  <= i_input_2;
            r_busy  <= 1'b1;
            r_state <= ST_CMP1;
          end
        end
        ST_CMP1: begin
          r_res_1    <= w_y;
          r_st_sat_1 <= w_sat;
          r_state    <= ST_CMP2;
        end
        ST_CMP2: begin
          r_res_2    <= w_y;
          r_st_sat_2 <= w_sat;
          r_state    <= ST_UPDATE;
        end
        ST_UPDATE: begin
          r_out_1 <= r_res_1;
          r_out_2 <= r_res_2;
          r_sat_1 <= r_st_sat_1;
          r_sat_2 <= r_st_sat_2;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_output_1 = r_out_1;
  assign o_output_2 = r_out_2;
  assign o_sat_1    = r_sat_1;
  assign o_sat_2    = r_sat_2;
  assign o_done_sig = r_done;
  assign o_busy     = r_busy;
  assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_control_output_limit.sv
// tb/tb_control_output_limit.sv - scoreboard bench for control_output_limit
module tb_control_output_limit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_user = 1'b0;
  logic        sta = 1'b0;
  logic [31:0] in1 = 32'h0, in2 = 32'h0;
  logic [31:0] out1, out2;
  logic [1:0]  sat1, sat2;
  logic        done, busy, overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] o1;
    logic [31:0] o2;
    logic [1:0]  s1;
    logic [1:0]  s2;
    int          cyc;
  } exp_t;
  exp_t q[$];

  control_output_limit dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_rst_user (rst_user),
    .i_sta      (sta),
    .i_input_1  (in1),
    .i_input_2  (in2),
    .o_output_1 (out1),
    .o_output_2 (out2),
    .o_sat_1    (sat1),
    .o_sat_2    (sat2),
    .o_done_sig (done),
    .o_busy     (busy),
    .o_overrun  (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("output_1", out1, e.o1);
        chk("output_2", out2, e.o2);
        chk("sat_1", {30'd0, sat1}, {30'd0, e.s1});
        chk("sat_2", {30'd0, sat2}, {30'd0, e.s2});
      end
    end
  end

  // Drive sta for one cycle starting just after a posedge; returns 1 cycle later.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push,
                       input logic [31:0] e1, input logic [1:0] s1,
                       input logic [31:0] e2, input logic [1:0] s2);
    exp_t e;
    sta = 1'b1; in1 = a; in2 = b;
    if (push) begin
      e.o1 = e1; e.o2 = e2; e.s1 = s1; e.s2 = s2; e.cyc = cyc + 4;
      q.push_back(e);
    end
    @(posedge clk); #1;
    sta = 1'b0;
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e1, input logic [1:0] s1,
                         input logic [31:0] e2, input logic [1:0] s2);
    issue(a, b, 1'b1, e1, s1, e2, s2);
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out1", out1, 32'h0);
    chk("reset_out2", out2, 32'h0);
    chk("reset_flags", {29'd0, done, busy, overrun}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Within limits, also confirm busy right after acceptance.
    issue(32'h3F000000, 32'h00000000, 1'b1, 32'h3F000000, 2'b00, 32'h00000000, 2'b00);
    chk("busy_after_sta", {31'd0, busy}, 32'd1);
    repeat (5) @(posedge clk); #1;
    chk("busy_idle", {31'd0, busy}, 32'd0);

    run_one(32'h3FC00000, 32'hBF800000, 32'h3F800000, 2'b10, 32'h00000000, 2'b01);
    run_one(32'h80000000, 32'h7F800000, 32'h00000000, 2'b00, 32'h3F800000, 2'b10);
    run_one(32'h7FC00000, 32'h3F800000, 32'h00000000, 2'b11, 32'h3F800000, 2'b00);
    run_one(32'hFF800000, 32'h00000001, 32'h00000000, 2'b01, 32'h00000001, 2'b00);
    run_one(32'h3F7FFFFF, 32'h3F800001, 32'h3F7FFFFF, 2'b00, 32'h3F800000, 2'b10);
    run_one(32'h7F800001, 32'h80000001, 32'h00000000, 2'b11, 32'h00000000, 2'b01);

    // Overrun: second sta one cycle later is ignored.
    chk("overrun_clear", {31'd0, overrun}, 32'd0);
    issue(32'h3F000000, 32'h3F000000, 1'b1, 32'h3F000000, 2'b00, 32'h3F000000, 2'b00);
    issue(32'h3FC00000, 32'hBF800000, 1'b0, 32'h0, 2'b00, 32'h0, 2'b00);
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    repeat (5) @(posedge clk); #1;
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);

    // Back-to-back: second sta lands in the done cycle.
    issue(32'h3FC00000, 32'h3F400000, 1'b1, 32'h3F800000, 2'b10, 32'h3F400000, 2'b00);
    repeat (3) @(posedge clk); #1;
    chk("done_in_b2b", {31'd0, done}, 32'd1);
    issue(32'h80000001, 32'h40000000, 1'b1, 32'h00000000, 2'b01, 32'h3F800000, 2'b10);
    repeat (5) @(posedge clk); #1;

    // rst_user one cycle after sta: conversion aborted, no done.
    issue(32'h3F000000, 32'h3F000000, 1'b0, 32'h0, 2'b00, 32'h0, 2'b00);
    rst_user = 1'b1;
    @(posedge clk); #1;
    rst_user = 1'b0;
    chk("ru_busy", {31'd0, busy}, 32'd0);
    chk("ru_out1", out1, 32'h0);
    chk("ru_out2", out2, 32'h0);
    chk("ru_sat", {28'd0, sat1, sat2}, 32'h0);
    chk("ru_overrun", {31'd0, overrun}, 32'd0);
    repeat (6) @(posedge clk); #1;

    // rst_user coincident with sta: sta dropped.
    sta = 1'b1; rst_user = 1'b1; in1 = 32'h3F000000; in2 = 32'h3F000000;
    @(posedge clk); #1;
    sta = 1'b0; rst_user = 1'b0;
    chk("ru_sta_busy", {31'd0, busy}, 32'd0);
    repeat (6) @(posedge clk); #1;

    // Async reset mid-conversion after outputs are non-zero.
    run_one(32'h3F000000, 32'h3FC00000, 32'h3F000000, 2'b00, 32'h3F800000, 2'b10);
    issue(32'h3F400000, 32'h3F400000, 1'b0, 32'h0, 2'b00, 32'h0, 2'b00);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out1", out1, 32'h0);
    chk("arst_out2", out2, 32'h0);
    chk("arst_flags", {25'd0, sat1, sat2, done, busy, overrun}, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (6) @(posedge clk); #1;

    chk("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish by 20000");
    $fatal(1, "timeout");
  end

endmodule
